// File: rtl/mux_stream_nto1.sv
// N-input registered stream mux with valid/ready on every port; fixed-select or round-robin grant.
// Optional accepted-beat counter output beat_cnt enabled by defining MUX_STREAM_STATS_EN.
module mux_stream_nto1 #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    input  logic            mode,
    input  logic [SW-1:0]   sel,
    output logic [W-1:0]    out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SW-1:0]   out_ch
`ifdef MUX_STREAM_STATS_EN
    ,
    output logic [15:0]     beat_cnt
`endif
);

    logic [W-1:0]  out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic [SW-1:0] out_ch_q, out_ch_d;
    logic [SW-1:0] rr_ptr_q, rr_ptr_d;

    logic          load;
    logic          grant_vld;
    logic [SW-1:0] grant_idx;
    logic          xfer;

    // rr_ptr is always < N, so a single conditional subtract is enough to wrap.
    function automatic logic [SW-1:0] wrap_add(input logic [SW-1:0] base, input int offs);
        int s;
        s = int'(base) + offs;
        if (s >= N) s = s - N;
        return SW'(s);
    endfunction

    assign load = !out_valid_q || out_ready;

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        if (!mode) begin
            // Compare against every legal index so sel >= N simply never matches.
            for (int i = 0; i < N; i++) begin
                if (sel == SW'(i) && in_valid[i]) begin
                    grant_vld = 1'b1;
                    grant_idx = SW'(i);
                end
            end
        end else begin
            // Walk offsets downward so the smallest offset from rr_ptr wins.
            for (int k = N - 1; k >= 0; k--) begin
                if (in_valid[wrap_add(rr_ptr_q, k)]) begin
                    grant_vld = 1'b1;
                    grant_idx = wrap_add(rr_ptr_q, k);
                end
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (!rst && load && grant_vld) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    assign xfer = load && grant_vld;

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_ch_d    = out_ch_q;
        rr_ptr_d    = rr_ptr_q;
        if (load) begin
            if (grant_vld) begin
                out_data_d  = in_data[int'(grant_idx)*W +: W];
                out_valid_d = 1'b1;
                out_ch_d    = grant_idx;
                rr_ptr_d    = wrap_add(grant_idx, 1);
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;

`ifdef MUX_STREAM_STATS_EN
    logic [15:0] beat_cnt_q, beat_cnt_d;

    // Saturating: once at all-ones the count sticks until reset.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (xfer && beat_cnt_q != 16'hFFFF) begin
            beat_cnt_d = beat_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt_q <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign beat_cnt = beat_cnt_q;
`else
    logic unused_xfer;
    assign unused_xfer = xfer;
`endif

endmodule

// File: tb/tb_mux_stream_nto1.sv
// Self-checking bench for mux_stream_nto1: directed scenarios plus randomized traffic against a reference model.
module tb_mux_stream_nto1;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic            mode;
    logic [SW-1:0]   sel;
    logic [W-1:0]    out_data;
    logic            out_valid;
    logic            out_ready;
    logic [SW-1:0]   out_ch;
`ifdef MUX_STREAM_STATS_EN
    logic [15:0]     beat_cnt;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic          m_valid;
    logic [W-1:0]  m_data;
    int            m_ch;
    int            m_ptr;
    int            m_cnt;

    mux_stream_nto1 #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch)
`ifdef MUX_STREAM_STATS_EN
        ,
        .beat_cnt  (beat_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic int model_grant();
        if (!mode) begin
            if (int'(sel) < N && in_valid[sel]) return int'(sel);
            return -1;
        end
        for (int k = 0; k < N; k++) begin
            if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] r;
        int g;
        r = '0;
        g = model_grant();
        if (!rst && (!m_valid || out_ready) && g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_ch    = 0;
        m_ptr   = 0;
        m_cnt   = 0;
    endtask

    // Advance one clock: called at a negedge, returns at the following negedge.
    task automatic model_tick();
        int g;
        logic ld;
        logic [W-1:0] d;
        g  = model_grant();
        ld = !m_valid || out_ready;
        d  = (g >= 0) ? in_data[g*W +: W] : '0;
        @(posedge clk);
        if (ld) begin
            if (g >= 0) begin
                m_valid = 1'b1;
                m_data  = d;
                m_ch    = g;
                m_ptr   = (g + 1) % N;
                if (m_cnt < 65535) m_cnt++;
            end else begin
                m_valid = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        model_reset();
        in_valid  = '1;
        in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
        mode      = 1'b1;
        sel       = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        total++;
        if (out_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", out_data); end
        total++;
        if (out_ch !== 2'd0) begin bad++; $display("FAIL reset_ch: got %0d want 0", out_ch); end
        total++;
        if (in_ready !== 4'b0000) begin bad++; $display("FAIL reset_in_ready: got %b want 0000", in_ready); end
`ifdef MUX_STREAM_STATS_EN
        total++;
        if (beat_cnt !== 16'h0000) begin bad++; $display("FAIL reset_beat_cnt: got %h want 0000", beat_cnt); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_fixed_select();
        do_reset();
        mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
        in_data = {8'h44, 8'h33, 8'h22, 8'h11};
        for (int i = 0; i < 6; i++) begin
            #1;
            total++;
            if (in_ready !== 4'b0100) begin bad++; $display("FAIL fixed_in_ready[%0d]: got %b want 0100", i, in_ready); end
            if (i > 0) begin
                total++;
                if (out_data !== 8'h33 || out_ch !== 2'd2 || out_valid !== 1'b1)
                    begin bad++; $display("FAIL fixed_out[%0d]: got v=%b d=%h ch=%0d want v=1 d=33 ch=2", i, out_valid, out_data, out_ch); end
            end
            model_tick();
        end
    endtask

    task automatic test_round_robin();
        int exp_ch[6];
        logic [7:0] exp_d[6];
        exp_ch = '{0, 1, 2, 3, 0, 1};
        exp_d  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11, 8'h22};
        do_reset();
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        in_data = {8'h44, 8'h33, 8'h22, 8'h11};
        for (int i = 0; i < 6; i++) begin
            model_tick();
            #1;
            total++;
            if (out_valid !== 1'b1 || int'(out_ch) != exp_ch[i] || out_data !== exp_d[i])
                begin bad++; $display("FAIL rr_seq[%0d]: got v=%b ch=%0d d=%h want v=1 ch=%0d d=%h", i, out_valid, out_ch, out_data, exp_ch[i], exp_d[i]); end
        end
    endtask

    task automatic test_skip_idle();
        do_reset();
        mode = 1'b1; in_valid = 4'b1010; out_ready = 1'b1;
        in_data = {8'h44, 8'h33, 8'h22, 8'h11};
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (in_ready[0] !== 1'b0 || in_ready[2] !== 1'b0)
                begin bad++; $display("FAIL skip_in_ready[%0d]: got %b want bits 0,2 low", i, in_ready); end
            model_tick();
            #1;
            total++;
            if (int'(out_ch) != ((i % 2 == 0) ? 1 : 3))
                begin bad++; $display("FAIL skip_ch[%0d]: got %0d want %0d", i, out_ch, (i % 2 == 0) ? 1 : 3); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        mode = 1'b0; sel = 2'd1; in_valid = 4'b1111; out_ready = 1'b1;
        in_data = {8'h44, 8'h33, 8'h22, 8'h11};
        model_tick();
        out_ready = 1'b0;
        in_data = {8'h44, 8'h33, 8'h55, 8'h11};
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if (out_valid !== 1'b1 || out_data !== 8'h22 || out_ch !== 2'd1)
                begin bad++; $display("FAIL bp_hold[%0d]: got v=%b d=%h ch=%0d want v=1 d=22 ch=1", i, out_valid, out_data, out_ch); end
            total++;
            if (in_ready !== 4'b0000) begin bad++; $display("FAIL bp_in_ready[%0d]: got %b want 0000", i, in_ready); end
            model_tick();
        end
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 4'b0010) begin bad++; $display("FAIL bp_release_ready: got %b want 0010", in_ready); end
        model_tick();
        #1;
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'h55)
            begin bad++; $display("FAIL bp_no_bubble: got v=%b d=%h want v=1 d=55", out_valid, out_data); end
    endtask

    task automatic test_async_reset();
        do_reset();
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        in_data = {8'h44, 8'h33, 8'h22, 8'h11};
        repeat (3) model_tick();
        #1;
        total++;
        if (out_valid !== 1'b1 || out_ch !== 2'd2)
            begin bad++; $display("FAIL arst_pre: got v=%b ch=%0d want v=1 ch=2", out_valid, out_ch); end
        rst = 1'b1;
        model_reset();
        #1;
        total++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0)
            begin bad++; $display("FAIL arst_immediate: got v=%b d=%h ch=%0d want 0 0 0", out_valid, out_data, out_ch); end
        total++;
        if (in_ready !== 4'b0000) begin bad++; $display("FAIL arst_in_ready: got %b want 0000", in_ready); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 4'b0001) begin bad++; $display("FAIL arst_first_ready: got %b want 0001", in_ready); end
        model_tick();
        #1;
        total++;
        if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 8'h11)
            begin bad++; $display("FAIL arst_first_grant: got v=%b ch=%0d d=%h want v=1 ch=0 d=11", out_valid, out_ch, out_data); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            in_valid  = N'($urandom);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            if ($urandom_range(0, 7) == 0) sel = SW'($urandom_range(0, 3));
            #1;
            total++;
            if (in_ready !== model_ready())
                begin bad++; $display("FAIL rand_in_ready[%0d]: got %b want %b", i, in_ready, model_ready()); end
            total++;
            if (out_valid !== m_valid || out_data !== m_data || int'(out_ch) != m_ch)
                begin bad++; $display("FAIL rand_out[%0d]: got v=%b d=%h ch=%0d want v=%b d=%h ch=%0d", i, out_valid, out_data, out_ch, m_valid, m_data, m_ch); end
`ifdef MUX_STREAM_STATS_EN
            total++;
            if (int'(beat_cnt) != m_cnt)
                begin bad++; $display("FAIL rand_beat_cnt[%0d]: got %0d want %0d", i, beat_cnt, m_cnt); end
`endif
            model_tick();
        end
    endtask

`ifdef MUX_STREAM_STATS_EN
    task automatic test_stats();
        do_reset();
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            @(posedge clk);
            if (i == 99) begin
                #1;
                total++;
                if (beat_cnt !== 16'd100) begin bad++; $display("FAIL stats_count100: got %0d want 100", beat_cnt); end
            end
        end
        @(negedge clk);
        total++;
        if (beat_cnt !== 16'hFFFF) begin bad++; $display("FAIL stats_saturate: got %h want ffff", beat_cnt); end
        repeat (5) @(posedge clk);
        @(negedge clk);
        total++;
        if (beat_cnt !== 16'hFFFF) begin bad++; $display("FAIL stats_hold: got %h want ffff", beat_cnt); end
        rst = 1'b1;
        #1;
        total++;
        if (beat_cnt !== 16'h0000) begin bad++; $display("FAIL stats_clear: got %h want 0000", beat_cnt); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask
`endif

    initial begin
        test_reset();
        test_fixed_select();
        test_round_robin();
        test_skip_idle();
        test_backpressure();
        test_async_reset();
        test_random();
`ifdef MUX_STREAM_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got still running want finished");
        $fatal(1, "timeout");
    end
endmodule
